bcd_scan_scheduler: RTL

- Shares one combinational BCD-to-seven-segment decoder among NDIG display digits.
- Decoder convention: active-low segments in [0:6] = a..g order; codes 10-15 decode to all-off.
- Holds one BCD register per digit, written by a simple write port.
- Sequences each digit's code through the decoder in round-robin order and latches the returned pattern into that digit's HEX output register.
- Optional leading-zero blanking. Sits between control logic (counters, switches) and the board HEX displays.

---
 rtl/bcd_scan_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bcd_scan_scheduler.sv
// -----------------------------------------------------------------------------
// bcd_scan_scheduler
//
// Time-shares one external combinational BCD-to-seven-segment decoder among
// NDIG display digits. Each digit owns a 4-bit BCD register, written through a
// simple write port. A round-robin FSM presents each digit's code on dec_bcd.
// It then latches the decoder's answer (dec_seg) into that digit's HEX output
// register, and holds the slot for DWELL cycles in total.
//
// Optional leading-zero blanking replaces the code of a digit with 4'hF (all
// segments off) when that digit and every more significant digit are zero.
// Digit 0 is never blanked.
//
// Ports:
//   CLOCK_50    in   1        system clock, rising edge
//   reset       in   1        synchronous, active-high reset
//   wr_en       in   1        write strobe for a digit register
//   wr_addr     in   AW       digit index to write (>= NDIG ignored)
//   wr_data     in   4        BCD code to store (10..15 stored as-is)
//   blank_lz    in   1        1 = blank leading zeros
//   dec_bcd     out  4        registered code presented to the shared decoder
//   dec_seg     in   [0:6]    decoder result, active-low a..g
//   HEX         out  NDIG*7   digit i segments at [7i +: 7], active-low
//   sweep_done  out  1        one-cycle pulse after the last digit's capture
// -----------------------------------------------------------------------------
module bcd_scan_scheduler #(
  parameter int NDIG  = 4,
  parameter int DWELL = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [$clog2(NDIG)-1:0] wr_addr,
  input  logic [3:0]              wr_data,
  input  logic                    blank_lz,
  output logic [3:0]              dec_bcd,
  input  logic [0:6]              dec_seg,
  output logic [NDIG*7-1:0]       HEX,
  output logic                    sweep_done
);

  localparam int AW = $clog2(NDIG);
  localparam int CW = (DWELL > 2) ? $clog2(DWELL) : 1;
  localparam logic [AW-1:0] LAST_IDX  = AW'(NDIG - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'((DWELL > 2) ? (DWELL - 3) : 0);

  typedef enum logic [1:0] {
    LOAD,
    CAPTURE,
    HOLD
  } state_t;

  state_t          state;
  logic [AW-1:0]   idx;
  logic [AW-1:0]   next_idx;
  logic [CW-1:0]   cnt;
  logic [3:0]      digit [NDIG];
  logic [NDIG-1:0] zero_from;   // zero_from[i]: digit[i..NDIG-1] all zero
  logic            all_zero;
  logic [3:0]      eff_code;

  // ---------------------------------------------------------------------------
  // Digit registers
  // ---------------------------------------------------------------------------
  // NOTE: this small register array is reset so a freshly reset display shows
  // zeros instead of power-up garbage; it is flops, not a RAM macro.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int i = 0; i < NDIG; i++) digit[i] <= 4'd0;
    end else if (wr_en && (int'(wr_addr) < NDIG)) begin
      // NOTE: non-blocking assignment so every flop samples pre-edge values.
      digit[wr_addr] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Leading-zero detection and effective code for the current slot
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the loop, so no latch is built.
  always_comb begin
    zero_from = '0;
    all_zero  = 1'b1;
    for (int i = NDIG - 1; i >= 0; i--) begin
      all_zero     = all_zero & (digit[i] == 4'd0);
      zero_from[i] = all_zero;
    end
  end

  always_comb begin
    eff_code = digit[idx];
    if (blank_lz && (idx != '0) && zero_from[idx]) eff_code = 4'hF;
  end

  assign next_idx = (idx == LAST_IDX) ? '0 : idx + 1'b1;

  // ---------------------------------------------------------------------------
  // Scan FSM: LOAD -> CAPTURE -> HOLD (DWELL-2 cycles) -> LOAD of next digit.
  // The captured pattern comes from the code registered at LOAD. A write to
  // the digit during CAPTURE therefore only shows up on the next sweep.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= LOAD;
      idx        <= '0;
      cnt        <= '0;
      dec_bcd    <= 4'hF;
      HEX        <= '1;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      case (state)
        LOAD: begin
          dec_bcd <= eff_code;
          state   <= CAPTURE;
        end
        CAPTURE: begin
          HEX[int'(idx) * 7 +: 7] <= dec_seg;
          sweep_done              <= (idx == LAST_IDX);
          cnt                     <= '0;
          if (DWELL == 2) begin
            idx   <= next_idx;
            state <= LOAD;
          end else begin
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            idx   <= next_idx;
            state <= LOAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule
